sirv_debug_entry_ctrl: RTL and testbench
========================================

# sirv_debug_entry_ctrl

Debug entry/exit sequencer between the commit stage and the debug CSR block. It watches committed instructions, the debug-module halt request and the dcsr halt/step/ebreakm bits. It decides when the core enters debug mode and with which cause and dpc. It produces the `cmt_dpc`/`cmt_dcause` update strobes consumed by the debug CSR block, and the flush/resume handshake toward the pipeline.

## Interface
Parameters:
- `PC_SIZE`, 32, PC width
- `HALT_WAIT`, 15, idle cycles with no commit before a pending halt is forced; ≥1

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset; one clock, synchronous, active-low
- `cmt_valid`  in  1  an instruction commits this cycle
- `cmt_pc`  in  PC_SIZE  PC of committing instruction
- `cmt_npc`  in  PC_SIZE  PC of next instruction after it
- `cmt_ebreak`  in  1  committing instruction is EBREAK
- `cmt_dret`  in  1  committing instruction is DRET
- `dbg_irq_r`  in  1  halt request from debug module, level
- `dbg_mode`  in  1  debug mode flag from debug CSR block
- `dbg_halt_r`  in  1  dcsr.halt
- `dbg_step_r`  in  1  dcsr.step
- `dbg_ebreakm_r`  in  1  dcsr.ebreakm
- `dbg_entry_ack`  in  1  pipeline flushed, redirected to debug ROM
- `dbg_entry_req`  out  1  request flush to debug ROM, level
- `dbg_resume`  out  1  one-cycle pulse, redirect to dpc
- `cmt_dpc`  out  PC_SIZE  dpc value to write
- `cmt_dpc_ena`  out  1  dpc write strobe
- `cmt_dcause`  out  3  dcause value to write
- `cmt_dcause_ena`  out  1  dcause write strobe

## Operation
- States: RUN, STEP (only with macro), ENTER, DEBUG.
- Halt source: `halt_src = dbg_irq_r | dbg_halt_r`.
- Cause codes: 1 ebreak, 3 haltreq, 4 step; 0 written on exit (clears dbg_mode).
- RUN / STEP, with `cmt_valid`. Priority is ebreak > haltreq > step:
  - `cmt_ebreak & dbg_ebreakm_r` → cause 1, dpc = `cmt_pc`
  - `halt_src` → cause 3, dpc = `cmt_npc`
  - state STEP → cause 4, dpc = `cmt_npc`
  - Any of these → latch cause/dpc, go ENTER.
- Idle-halt counter:
  - In RUN/STEP while `halt_src` and no `cmt_valid`, counter increments; otherwise it clears.
  - At `HALT_WAIT` → cause 3, dpc = last latched `cmt_npc` (reset value 0), go ENTER.
  - Counter saturates; width `$clog2(HALT_WAIT+1)`.
- EBREAK with `dbg_ebreakm_r=0`: no action; the pipeline's own exception path handles it.
- ENTER:
  - `dbg_entry_req=1`.
  - `cmt_valid` ignored; the pipeline guarantees no commit.
  - On `dbg_entry_ack` → pulse `cmt_dpc_ena` and `cmt_dcause_ena` with latched values, go DEBUG.
- DEBUG:
  - `cmt_valid & cmt_dret` → pulse `cmt_dcause_ena` with `cmt_dcause=0`, pulse `dbg_resume`.
  - Next state is STEP if `dbg_step_r`, else RUN. `cmt_dpc_ena` stays 0.
  - EBREAK/halt in DEBUG: ignored (debug ROM handles it).
- `dbg_mode` input is a consistency check only. DEBUG with `dbg_mode=0` is legal for the one cycle after entry.
- DRET outside DEBUG: ignored.

## Timing
- Reset values: state RUN, all outputs 0, counter 0, latched cause 0, latched dpc 0.
- Entry event at commit cycle N → `dbg_entry_req` high from N+1.
- Ack sampled at cycle M (M ≥ N+1) → strobes high exactly at M+1 (registered), `dbg_entry_req` low at M+1, state DEBUG at M+1.
- Ack in the same cycle `dbg_entry_req` first rises is legal.
- Ack while not in ENTER is ignored.
- DRET commit at cycle K → `cmt_dcause_ena` and `dbg_resume` high at K+1 for one cycle.
  - The first instruction committing at ≥K+2 is the step instruction.
- Idle halt: `halt_src` rises at cycle H with no commits → ENTER at H+HALT_WAIT.
- Reset asserted mid-ENTER or mid-DEBUG → RUN next edge, strobes suppressed.

## Configuration
- `SIRV_DEBUG_STEP_EN` defined: STEP state and cause-4 entry as above.
- Not defined:
  - STEP state removed.
  - DRET always returns to RUN.
  - `dbg_step_r` is ignored.
  - Cause 4 is never produced.

## Structure
- Shared package constants:
  - cause codes `DCAUSE_NONE=0`, `DCAUSE_EBREAK=1`, `DCAUSE_HALT=3`, `DCAUSE_STEP=4`
  - 2-bit state encoding
- Registers built from the team's general synchronous-reset enable-flop primitive.
- One natural sub-module: `sirv_debug_halt_timer` (idle-halt saturating counter).

## Test plan
- EBREAK at `cmt_pc=0x8000_0010` with ebreakm=1, ack 2 cycles after req → `cmt_dcause=1`, `cmt_dpc=0x8000_0010`, strobes one cycle after ack.
- `dbg_irq_r` high, commit with `cmt_npc=0x8000_0024` → cause 3, dpc `0x8000_0024`.
- Simultaneous EBREAK and `dbg_irq_r` on the same commit → cause 1 wins.
- `dbg_irq_r` with no commits, HALT_WAIT=15, last npc `0x100` → `dbg_entry_req` at cycle 16, dpc `0x100`.
- DRET with step=1 (macro on) → dcause 0 written, `dbg_resume` pulse; next commit npc `0x204` → cause 4, dpc `0x204`. With macro off → no re-entry.
- Reset during ENTER → no strobes, RUN; ebreakm=0 EBREAK → no entry.

Source files
------------

// File: rtl/sirv_debug_entry_ctrl_pkg.sv
// Shared constants for the debug entry/exit sequencer: dcause codes,
// 2-bit FSM state encoding and a small state helper.
package sirv_debug_entry_ctrl_pkg;

    localparam int DCAUSE_W = 3;

    localparam logic [DCAUSE_W-1:0] DCAUSE_NONE   = 3'd0;
    localparam logic [DCAUSE_W-1:0] DCAUSE_EBREAK = 3'd1;
    localparam logic [DCAUSE_W-1:0] DCAUSE_HALT   = 3'd3;
    localparam logic [DCAUSE_W-1:0] DCAUSE_STEP   = 3'd4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STEP  = 2'd1,
        ST_ENTER = 2'd2,
        ST_DEBUG = 2'd3
    } dbg_state_e;

    // RUN and STEP both watch commits and run the idle-halt counter.
    function automatic logic is_run_like(input dbg_state_e s);
        return (s == ST_RUN) || (s == ST_STEP);
    endfunction

endpackage

// File: rtl/sirv_debug_entry_ctrl_if.sv
// Commit / debug-CSR / pipeline handshake bundle for sirv_debug_entry_ctrl.
// master: the sequencer. slave: the pipeline and debug CSR side.
interface sirv_debug_entry_ctrl_if
    import sirv_debug_entry_ctrl_pkg::*;
#(
    parameter int PC_SIZE = 32
);
    logic                cmt_valid;
    logic [PC_SIZE-1:0]  cmt_pc;
    logic [PC_SIZE-1:0]  cmt_npc;
    logic                cmt_ebreak;
    logic                cmt_dret;
    logic                dbg_irq_r;
    logic                dbg_mode;
    logic                dbg_halt_r;
    logic                dbg_step_r;
    logic                dbg_ebreakm_r;
    logic                dbg_entry_ack;

    logic                dbg_entry_req;
    logic                dbg_resume;
    logic [PC_SIZE-1:0]  cmt_dpc;
    logic                cmt_dpc_ena;
    logic [DCAUSE_W-1:0] cmt_dcause;
    logic                cmt_dcause_ena;

    modport master (
        input  cmt_valid, cmt_pc, cmt_npc, cmt_ebreak, cmt_dret,
        input  dbg_irq_r, dbg_mode, dbg_halt_r, dbg_step_r, dbg_ebreakm_r,
        input  dbg_entry_ack,
        output dbg_entry_req, dbg_resume, cmt_dpc, cmt_dpc_ena,
        output cmt_dcause, cmt_dcause_ena
    );

    modport slave (
        output cmt_valid, cmt_pc, cmt_npc, cmt_ebreak, cmt_dret,
        output dbg_irq_r, dbg_mode, dbg_halt_r, dbg_step_r, dbg_ebreakm_r,
        output dbg_entry_ack,
        input  dbg_entry_req, dbg_resume, cmt_dpc, cmt_dpc_ena,
        input  cmt_dcause, cmt_dcause_ena
    );

endinterface

// File: rtl/sirv_debug_halt_timer.sv
// Idle-halt saturating counter. Counts cycles with a pending halt and no
// commit; fire is asserted in the cycle the count would reach HALT_WAIT,
// so the sequencer is in ENTER HALT_WAIT cycles after the halt first arrives.
module sirv_debug_halt_timer #(
    parameter int HALT_WAIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cnt_inc,
    output logic fire
);

    localparam int CW = $clog2(HALT_WAIT + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(HALT_WAIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(HALT_WAIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_q;

    // Saturating increment while idle with a halt pending, clear otherwise.
    always_comb begin
        cnt_d = '0;
        if (cnt_inc) begin
            cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
        end
    end

    assign fire = cnt_inc & (cnt_q >= CNT_LAST);

    sirv_gnrl_dfflr #(.DW(CW)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .lden  (1'b1),
        .dnxt  (cnt_d),
        .qout  (cnt_q)
    );

endmodule

// File: rtl/sirv_gnrl_dfflr.sv
// General-purpose flop with load enable and synchronous active-low reset to 0.
module sirv_gnrl_dfflr #(
    parameter int DW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout
);

    // Load on enable, clear on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            qout <= '0;
        end else if (lden) begin
            qout <= dnxt;
        end
    end

endmodule

// File: rtl/sirv_debug_entry_ctrl.sv
// Debug entry/exit sequencer between commit stage and debug CSR block.
// Optional single-step support is enabled by defining SIRV_DEBUG_STEP_EN.
//
// state | meaning
// RUN   | normal execution, watching commits and halt requests
// STEP  | resumed with dcsr.step, next commit re-enters with cause 4
// ENTER | flush to debug ROM requested, waiting for ack
// DEBUG | executing debug ROM, waiting for DRET
module sirv_debug_entry_ctrl
    import sirv_debug_entry_ctrl_pkg::*;
#(
    parameter int PC_SIZE   = 32,
    parameter int HALT_WAIT = 15
) (
    input logic                      clk,
    input logic                      rst_n,
    sirv_debug_entry_ctrl_if.master  dbg_if
);

    dbg_state_e          state_q;
    dbg_state_e          state_d;
    logic [1:0]          state_raw_q;
    logic [DCAUSE_W-1:0] cause_lat_d, cause_lat_q;
    logic [PC_SIZE-1:0]  dpc_lat_d, dpc_lat_q;
    logic [PC_SIZE-1:0]  npc_last_q;
    logic [DCAUSE_W-1:0] dcause_out_d, dcause_out_q;
    logic [PC_SIZE-1:0]  dpc_out_d, dpc_out_q;
    logic [2:0]          strobe_d, strobe_q;

    logic halt_src, run_like, step_mode, idle_inc, idle_fire;
    logic ack_go, dret_go, npc_ena;
    dbg_state_e resume_state;

    assign state_q  = dbg_state_e'(state_raw_q);
    assign halt_src = dbg_if.dbg_irq_r | dbg_if.dbg_halt_r;
    assign run_like = is_run_like(state_q);
    assign idle_inc = run_like & halt_src & ~dbg_if.cmt_valid;
    assign ack_go   = (state_q == ST_ENTER) & dbg_if.dbg_entry_ack;
    assign dret_go  = (state_q == ST_DEBUG) & dbg_if.cmt_valid & dbg_if.cmt_dret;
    assign npc_ena  = run_like & dbg_if.cmt_valid;

`ifdef SIRV_DEBUG_STEP_EN
    assign step_mode    = (state_q == ST_STEP);
    assign resume_state = dbg_if.dbg_step_r ? ST_STEP : ST_RUN;
`else
    assign step_mode    = 1'b0;
    assign resume_state = ST_RUN;
`endif

    sirv_debug_halt_timer #(.HALT_WAIT(HALT_WAIT)) u_halt_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .cnt_inc (idle_inc),
        .fire    (idle_fire)
    );

    // Next state and entry cause/dpc latch; ebreak beats haltreq beats step.
    always_comb begin
        state_d     = state_q;
        cause_lat_d = cause_lat_q;
        dpc_lat_d   = dpc_lat_q;
        case (state_q)
            ST_RUN, ST_STEP: begin
                if (dbg_if.cmt_valid) begin
                    if (dbg_if.cmt_ebreak & dbg_if.dbg_ebreakm_r) begin
                        cause_lat_d = DCAUSE_EBREAK;
                        dpc_lat_d   = dbg_if.cmt_pc;
                        state_d     = ST_ENTER;
                    end else if (halt_src) begin
                        cause_lat_d = DCAUSE_HALT;
                        dpc_lat_d   = dbg_if.cmt_npc;
                        state_d     = ST_ENTER;
                    end else if (step_mode) begin
                        cause_lat_d = DCAUSE_STEP;
                        dpc_lat_d   = dbg_if.cmt_npc;
                        state_d     = ST_ENTER;
                    end
                end else if (idle_fire) begin
                    cause_lat_d = DCAUSE_HALT;
                    dpc_lat_d   = npc_last_q;
                    state_d     = ST_ENTER;
                end
            end
            ST_ENTER: begin
                if (dbg_if.dbg_entry_ack) begin
                    state_d = ST_DEBUG;
                end
            end
            ST_DEBUG: begin
                if (dret_go) begin
                    state_d = resume_state;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Registered CSR write values and one-cycle strobes {dpc_ena, dcause_ena, resume}.
    always_comb begin
        dcause_out_d = dcause_out_q;
        dpc_out_d    = dpc_out_q;
        if (ack_go) begin
            dcause_out_d = cause_lat_q;
            dpc_out_d    = dpc_lat_q;
        end else if (dret_go) begin
            dcause_out_d = DCAUSE_NONE;
        end
        strobe_d = {ack_go, ack_go | dret_go, dret_go};
    end

    sirv_gnrl_dfflr #(.DW(2))        u_state    (.clk(clk), .rst_n(rst_n), .lden(1'b1),
                                                 .dnxt(state_d),      .qout(state_raw_q));
    sirv_gnrl_dfflr #(.DW(DCAUSE_W)) u_cause    (.clk(clk), .rst_n(rst_n), .lden(1'b1),
                                                 .dnxt(cause_lat_d),  .qout(cause_lat_q));
    sirv_gnrl_dfflr #(.DW(PC_SIZE))  u_dpc      (.clk(clk), .rst_n(rst_n), .lden(1'b1),
                                                 .dnxt(dpc_lat_d),    .qout(dpc_lat_q));
    sirv_gnrl_dfflr #(.DW(PC_SIZE))  u_npc_last (.clk(clk), .rst_n(rst_n), .lden(npc_ena),
                                                 .dnxt(dbg_if.cmt_npc), .qout(npc_last_q));
    sirv_gnrl_dfflr #(.DW(DCAUSE_W)) u_dcause_o (.clk(clk), .rst_n(rst_n), .lden(1'b1),
                                                 .dnxt(dcause_out_d), .qout(dcause_out_q));
    sirv_gnrl_dfflr #(.DW(PC_SIZE))  u_dpc_o    (.clk(clk), .rst_n(rst_n), .lden(1'b1),
                                                 .dnxt(dpc_out_d),    .qout(dpc_out_q));
    sirv_gnrl_dfflr #(.DW(3))        u_strobe   (.clk(clk), .rst_n(rst_n), .lden(1'b1),
                                                 .dnxt(strobe_d),     .qout(strobe_q));

    assign dbg_if.dbg_entry_req  = (state_q == ST_ENTER);
    assign dbg_if.cmt_dpc        = dpc_out_q;
    assign dbg_if.cmt_dcause     = dcause_out_q;
    assign dbg_if.cmt_dpc_ena    = strobe_q[2];
    assign dbg_if.cmt_dcause_ena = strobe_q[1];
    assign dbg_if.dbg_resume     = strobe_q[0];

endmodule

// File: tb/tb_sirv_debug_entry_ctrl.sv
// Testbench for sirv_debug_entry_ctrl. Define SIRV_DEBUG_STEP_EN to match the DUT build.
module tb_sirv_debug_entry_ctrl;

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;

    sirv_debug_entry_ctrl_if #(.PC_SIZE(32)) dif ();

    sirv_debug_entry_ctrl #(.PC_SIZE(32), .HALT_WAIT(15)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .dbg_if (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        dpc_ena;
        logic [31:0] dpc;
        logic        dcause_ena;
        logic [2:0]  dcause;
        logic        resume;
    } exp_t;

    typedef struct {
        logic        ebreak;
        logic        dret;
        logic        irq;
        logic        halt;
        logic        ebreakm;
        logic [31:0] pc;
        logic [31:0] npc;
        logic        exp_entry;
        logic [2:0]  exp_cause;
        logic [31:0] exp_dpc;
        int          ack_dly;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Debug CSR stand-in: dbg_mode follows the dcause writes.
    always @(posedge clk) begin
        if (!rst_n) dif.dbg_mode <= 1'b0;
        else if (dif.cmt_dcause_ena) dif.dbg_mode <= (dif.cmt_dcause != 3'd0);
    end

    // Scoreboard: every strobe cycle must match the oldest expected record.
    always @(negedge clk) begin
        if (dif.cmt_dpc_ena || dif.cmt_dcause_ena || dif.dbg_resume) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe",
                      {dif.cmt_dpc_ena, dif.cmt_dcause_ena, dif.dbg_resume}, 64'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("strobe_record",
                      {dif.cmt_dpc_ena, (e.dpc_ena ? dif.cmt_dpc : 32'h0),
                       dif.cmt_dcause_ena, dif.cmt_dcause, dif.dbg_resume},
                      {e.dpc_ena, (e.dpc_ena ? e.dpc : 32'h0),
                       e.dcause_ena, e.dcause, e.resume});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic dpe, input logic [31:0] dpc, input logic dce,
                            input logic [2:0] dc, input logic res);
        exp_t e;
        e.dpc_ena = dpe; e.dpc = dpc; e.dcause_ena = dce; e.dcause = dc; e.resume = res;
        exp_q.push_back(e);
    endtask

    task automatic clear_in();
        dif.cmt_valid = 0; dif.cmt_ebreak = 0; dif.cmt_dret = 0;
        dif.dbg_irq_r = 0; dif.dbg_halt_r = 0; dif.dbg_entry_ack = 0;
    endtask

    // One commit cycle, then inputs return to idle.
    task automatic do_commit(input logic eb, input logic dr, input logic irq, input logic hlt,
                             input logic ebm, input logic [31:0] pc, input logic [31:0] npc);
        dif.cmt_valid = 1; dif.cmt_ebreak = eb; dif.cmt_dret = dr;
        dif.dbg_irq_r = irq; dif.dbg_halt_r = hlt; dif.dbg_ebreakm_r = ebm;
        dif.cmt_pc = pc; dif.cmt_npc = npc;
        tick();
        clear_in();
    endtask

    // Called while req is expected high; acks after dly cycles.
    task automatic ack_entry(input int dly, input logic [2:0] cause, input logic [31:0] dpc);
        check("req_rise", dif.dbg_entry_req, 1);
        push_exp(1, dpc, 1, cause, 0);
        for (int i = 0; i < dly; i++) begin
            tick();
            check("req_hold", dif.dbg_entry_req, 1);
        end
        dif.dbg_entry_ack = 1;
        tick();
        dif.dbg_entry_ack = 0;
        check("req_drop", dif.dbg_entry_req, 0);
    endtask

    task automatic dret_exit(input logic step);
        dif.dbg_step_r = step;
        push_exp(0, 32'h0, 1, 3'd0, 1);
        do_commit(0, 1, 0, 0, 0, 32'h0000_0800, 32'h0000_0804);
        dif.dbg_step_r = 0;
        tick();
    endtask

    initial begin
        vecs[0] = '{1, 0, 0, 0, 1, 32'h8000_0010, 32'h8000_0014, 1, 3'd1, 32'h8000_0010, 2};
        vecs[1] = '{0, 0, 1, 0, 0, 32'h8000_0020, 32'h8000_0024, 1, 3'd3, 32'h8000_0024, 0};
        vecs[2] = '{1, 0, 1, 0, 1, 32'h8000_0030, 32'h8000_0034, 1, 3'd1, 32'h8000_0030, 1};
        vecs[3] = '{1, 0, 0, 0, 0, 32'h8000_0040, 32'h8000_0044, 0, 3'd0, 32'h0, 0};
        vecs[4] = '{0, 0, 0, 1, 0, 32'h8000_0050, 32'h8000_0054, 1, 3'd3, 32'h8000_0054, 3};
        vecs[5] = '{1, 0, 1, 0, 0, 32'h8000_0060, 32'h8000_0064, 1, 3'd3, 32'h8000_0064, 0};
        vecs[6] = '{0, 1, 0, 0, 1, 32'h8000_0070, 32'h8000_0074, 0, 3'd0, 32'h0, 0};
        vecs[7] = '{0, 0, 0, 0, 1, 32'h8000_0080, 32'h8000_0084, 0, 3'd0, 32'h0, 0};

        rst_n = 0;
        clear_in();
        dif.dbg_step_r = 0; dif.dbg_ebreakm_r = 0;
        dif.cmt_pc = '0; dif.cmt_npc = '0;
        tick(); tick();
        check("reset_outputs",
              {dif.dbg_entry_req, dif.dbg_resume, dif.cmt_dpc_ena, dif.cmt_dcause_ena,
               dif.cmt_dcause, dif.cmt_dpc}, 64'h0);
        rst_n = 1;
        tick();

        // Table: single commit from RUN, entry (or not), then DRET back to RUN.
        for (int v = 0; v < 8; v++) begin
            do_commit(vecs[v].ebreak, vecs[v].dret, vecs[v].irq, vecs[v].halt,
                      vecs[v].ebreakm, vecs[v].pc, vecs[v].npc);
            if (vecs[v].exp_entry) begin
                ack_entry(vecs[v].ack_dly, vecs[v].exp_cause, vecs[v].exp_dpc);
                dret_exit(0);
            end else begin
                check("no_entry", dif.dbg_entry_req, 0);
                tick();
                check("no_entry_late", dif.dbg_entry_req, 0);
            end
        end

        // Ack outside ENTER does nothing.
        dif.dbg_entry_ack = 1;
        tick();
        dif.dbg_entry_ack = 0;
        check("stray_ack", dif.dbg_entry_req, 0);
        tick();

        // Idle halt: last npc 0x100, irq held with no commits.
        do_commit(0, 0, 0, 0, 0, 32'h0000_00FC, 32'h0000_0100);
        dif.dbg_irq_r = 1;
        for (int i = 1; i <= 14; i++) begin
            tick();
            check("idle_wait", dif.dbg_entry_req, 0);
        end
        tick();
        dif.dbg_irq_r = 0;
        ack_entry(1, 3'd3, 32'h0000_0100);
        dret_exit(0);

        // DRET with step set; next commit re-enters with cause 4 only when stepping exists.
        do_commit(0, 0, 1, 0, 0, 32'h0000_01EC, 32'h0000_01F0);
        ack_entry(0, 3'd3, 32'h0000_01F0);
        dret_exit(1);
        do_commit(0, 0, 0, 0, 0, 32'h0000_0200, 32'h0000_0204);
`ifdef SIRV_DEBUG_STEP_EN
        ack_entry(1, 3'd4, 32'h0000_0204);
        dret_exit(0);
`else
        check("no_step_entry", dif.dbg_entry_req, 0);
        tick();
`endif

        // Reset during ENTER: ack in the same cycle is lost, no strobes.
        do_commit(1, 0, 0, 0, 1, 32'h9000_0000, 32'h9000_0004);
        check("enter_before_rst", dif.dbg_entry_req, 1);
        rst_n = 0;
        dif.dbg_entry_ack = 1;
        tick();
        rst_n = 1;
        dif.dbg_entry_ack = 0;
        check("rst_enter_req", dif.dbg_entry_req, 0);
        tick();
        check("rst_enter_stay", dif.dbg_entry_req, 0);

        // Reset during DEBUG: DRET in the reset cycle produces no resume.
        do_commit(0, 0, 1, 0, 0, 32'h9000_0010, 32'h9000_0014);
        ack_entry(0, 3'd3, 32'h9000_0014);
        rst_n = 0;
        dif.cmt_valid = 1; dif.cmt_dret = 1;
        tick();
        clear_in();
        rst_n = 1;
        check("rst_debug_dcause", dif.cmt_dcause, 0);
        tick();
        check("rst_debug_req", dif.dbg_entry_req, 0);

        // After reset the controller still enters normally.
        do_commit(1, 0, 0, 0, 1, 32'h9000_0020, 32'h9000_0024);
        ack_entry(0, 3'd1, 32'h9000_0020);
        dret_exit(0);

        tick(); tick();
        check("sb_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
